// File: rtl/param_compare_display.sv
// rtl/param_compare_display.sv - debounced signed/unsigned magnitude comparator with LED/7-seg display and change counter
//
// Purpose:
//   Registers {eq,gt,lt} of a vs b each clock. A result is committed only after
//   it has been identical for STABLE_CYCLES consecutive edges. The committed
//   result drives one-hot LEDs and a 7-segment character (E / L / G). Committed
//   result changes are counted, saturating.
//
// Ports:
//   MAX10_CLK1_50  in   system clock, rising edge
//   reset          in   synchronous, active-high reset
//   a, b           in   WIDTH-bit operands
//   signed_mode    in   1 = two's-complement compare, 0 = unsigned
//   hold           in   1 = freeze committed result and display
//   clear_cnt      in   synchronous clear of change_count
//   LEDR           out  [2] eq, [1] gt, [0] lt; [3] settling; [9:4] change_count[5:0]
//   HEX3           out  active-low segments {dp,g..a} of committed result
//   change_count   out  saturating count of committed result changes
//   change_pulse   out  one-cycle strobe after each counted commit

module param_compare_display #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                 MAX10_CLK1_50,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    input  logic                 hold,
    input  logic                 clear_cnt,
    output logic [9:0]           LEDR,
    output logic [7:0]           HEX3,
    output logic [CNT_WIDTH-1:0] change_count,
    output logic                 change_pulse
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]        CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [CW:0]          STABLE_W = (CW + 1)'(STABLE_CYCLES);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [CNT_WIDTH-1:0] CC_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOCKED = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      raw_q;
    logic [2:0]      cand;
    logic [2:0]      res;
    logic [CW-1:0]   cnt;

    logic            eq_c, lt_c, gt_c;
    logic [CW:0]     cnt_p1;
    logic            commit;
    logic            count_inc;
    logic [CNT_WIDTH+5:0] cc_ext;

    // Raw comparison, {eq,gt,lt}; exactly one bit is set.
    always_comb begin
        eq_c = (a == b);
        if (signed_mode) begin
            lt_c = ($signed(a) < $signed(b));
        end else begin
            lt_c = (a < b);
        end
        gt_c = !eq_c && !lt_c;
    end

    // cand == 0 only right after reset; it is never a valid result, so it
    // must not be committed even when the counter would allow it.
    always_comb begin
        cnt_p1    = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
        commit    = (raw_q == cand) && (cand != 3'b000) && (cnt_p1 >= STABLE_W) && !hold;
        count_inc = commit && (cand != res) && (state_q != S_IDLE);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (commit) state_d = S_LOCKED;
            S_LOCKED: if (hold)   state_d = S_HOLD;
            S_HOLD:   if (!hold)  state_d = S_LOCKED;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            state_q      <= S_IDLE;
            raw_q        <= 3'b000;
            cand         <= 3'b000;
            cnt          <= '0;
            res          <= 3'b000;
            change_count <= '0;
            change_pulse <= 1'b0;
        end else begin
            state_q <= state_d;
            raw_q   <= {eq_c, gt_c, lt_c};

            // Any difference restarts the stability count at 1.
            if (raw_q != cand) begin
                cand <= raw_q;
                cnt  <= CNT_ONE;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_ONE;
            end

            if (commit) begin
                res <= cand;
            end

            // Clear wins over an increment; the strobe still reports the commit.
            if (clear_cnt) begin
                change_count <= '0;
            end else if (count_inc && (change_count != CC_MAX)) begin
                change_count <= change_count + 1'b1;
            end
            change_pulse <= count_inc;
        end
    end

    // Display decode, from registers only.
    always_comb begin
        cc_ext = {6'b000000, change_count};
        LEDR   = 10'b0;
        HEX3   = 8'hFF;
        LEDR[9:4] = cc_ext[5:0];
        LEDR[3]   = (cand != res) || (state_q == S_IDLE);
        if (state_q != S_IDLE) begin
            LEDR[2:0] = res;
            case (res)
                3'b100:  HEX3 = 8'h86;
                3'b001:  HEX3 = 8'hC7;
                3'b010:  HEX3 = 8'hC2;
                default: HEX3 = 8'hFF;
            endcase
        end
    end

endmodule

// File: tb/tb_param_compare_display.sv
// tb/tb_param_compare_display.sv - table-driven self-checking bench for param_compare_display

module tb_param_compare_display;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, signed_mode, hold, clear_cnt;
    logic [3:0] a, b;
    logic [9:0] ledr, ledr2;
    logic [7:0] hex3, hex3_2;
    logic [7:0] cc;
    logic [1:0] cc2;
    logic       cp, cp2;

    param_compare_display #(.WIDTH(4), .STABLE_CYCLES(4), .CNT_WIDTH(8)) dut (
        .MAX10_CLK1_50(clk), .reset(reset), .a(a), .b(b), .signed_mode(signed_mode),
        .hold(hold), .clear_cnt(clear_cnt), .LEDR(ledr), .HEX3(hex3),
        .change_count(cc), .change_pulse(cp)
    );

    param_compare_display #(.WIDTH(4), .STABLE_CYCLES(4), .CNT_WIDTH(2)) dut2 (
        .MAX10_CLK1_50(clk), .reset(reset), .a(a), .b(b), .signed_mode(signed_mode),
        .hold(hold), .clear_cnt(clear_cnt), .LEDR(ledr2), .HEX3(hex3_2),
        .change_count(cc2), .change_pulse(cp2)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sm;
        logic [2:0] res;
    } vec_t;

    vec_t       tbl [12];
    int         checks = 0;
    int         errors = 0;
    int         exp_cnt  = 0;
    int         exp_cnt2 = 0;
    logic [2:0] prev = 3'b000;

    localparam logic [2:0] EQ = 3'b100;
    localparam logic [2:0] GT = 3'b010;
    localparam logic [2:0] LT = 3'b001;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] hex_of(input logic [2:0] r);
        case (r)
            3'b100:  return 8'h86;
            3'b001:  return 8'hC7;
            3'b010:  return 8'hC2;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic chk_res(input string tag, input logic [2:0] r);
        chk({tag, " leds"}, {29'd0, ledr[2:0]}, {29'd0, r});
        chk({tag, " hex"}, {24'd0, hex3}, {24'd0, hex_of(r)});
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, " count"}, {24'd0, cc}, exp_cnt);
        chk({tag, " count2"}, {30'd0, cc2}, exp_cnt2);
        chk({tag, " ledr_cnt"}, {26'd0, ledr[9:4]}, exp_cnt % 64);
        chk({tag, " ledr2_cnt"}, {26'd0, ledr2[9:4]}, exp_cnt2);
    endtask

    // Applies operands, checks nothing moves before edge 4, then checks the commit.
    task automatic apply(input string tag, input logic [3:0] va, input logic [3:0] vb,
                         input logic sm, input logic [2:0] r);
        logic changed;
        a = va; b = vb; signed_mode = sm;
        step(4);
        chk({tag, " pre leds"}, {29'd0, ledr[2:0]}, {29'd0, prev});
        chk({tag, " pre pulse"}, {31'd0, cp}, 32'd0);
        step(1);
        changed = (r != prev);
        if (changed) begin
            exp_cnt++;
            if (exp_cnt2 < 3) exp_cnt2++;
        end
        chk_res(tag, r);
        chk({tag, " settling"}, {31'd0, ledr[3]}, 32'd0);
        chk({tag, " pulse"}, {31'd0, cp}, {31'd0, changed});
        chk({tag, " pulse2"}, {31'd0, cp2}, {31'd0, changed});
        chk_counts(tag);
        prev = r;
    endtask

    initial begin
        tbl[0]  = '{4'h5, 4'h5, 1'b0, EQ};
        tbl[1]  = '{4'h8, 4'h1, 1'b0, GT};
        tbl[2]  = '{4'h8, 4'h1, 1'b1, LT};
        tbl[3]  = '{4'h7, 4'h8, 1'b0, LT};
        tbl[4]  = '{4'h7, 4'h8, 1'b1, GT};
        tbl[5]  = '{4'hF, 4'h0, 1'b1, LT};
        tbl[6]  = '{4'hF, 4'h0, 1'b0, GT};
        tbl[7]  = '{4'h0, 4'h0, 1'b1, EQ};
        tbl[8]  = '{4'h9, 4'hA, 1'b1, LT};
        tbl[9]  = '{4'hA, 4'h9, 1'b1, GT};
        tbl[10] = '{4'h0, 4'hF, 1'b0, LT};
        tbl[11] = '{4'h3, 4'h3, 1'b0, EQ};

        reset = 1'b1; hold = 1'b0; clear_cnt = 1'b0;
        a = 4'h5; b = 4'h5; signed_mode = 1'b0;
        step(2);

        // Reset state: blank display, no result, counters zero, idle flagged as settling.
        chk("rst leds", {29'd0, ledr[2:0]}, 32'd0);
        chk("rst hex", {24'd0, hex3}, 32'hFF);
        chk("rst settling", {31'd0, ledr[3]}, 32'd1);
        chk("rst pulse", {31'd0, cp}, 32'd0);
        chk_counts("rst");

        // First commit after STABLE_CYCLES+1 edges; does not count as a change.
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("t1 hex blank", {24'd0, hex3}, 32'hFF);
            chk("t1 leds blank", {29'd0, ledr[2:0]}, 32'd0);
        end
        step(1);
        chk_res("t1", EQ);
        chk("t1 pulse", {31'd0, cp}, 32'd0);
        chk_counts("t1");
        prev = EQ;

        // Two-cycle glitch never reaches the outputs.
        a = 4'h3; b = 4'h9;
        step(2);
        chk("t2 settling hi", {31'd0, ledr[3]}, 32'd1);
        chk_res("t2 glitch", EQ);
        a = 4'h5; b = 4'h5;
        step(1);
        chk("t2 settling still", {31'd0, ledr[3]}, 32'd1);
        step(1);
        chk("t2 settling lo", {31'd0, ledr[3]}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk_res("t2 after", EQ);
            chk("t2 pulse", {31'd0, cp}, 32'd0);
        end
        chk_counts("t2");

        for (int i = 0; i < 12; i++) begin
            apply($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].sm, tbl[i].res);
        end

        // Hold freezes LT while inputs say GT; release commits on the next edge.
        apply("t4 lt", 4'h0, 4'hF, 1'b0, LT);
        hold = 1'b1; a = 4'hF; b = 4'h0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk_res("t4 held", LT);
            chk("t4 held pulse", {31'd0, cp}, 32'd0);
        end
        chk("t4 settling", {31'd0, ledr[3]}, 32'd1);
        hold = 1'b0;
        step(1);
        exp_cnt++;
        chk_res("t4 release", GT);
        chk("t4 pulse", {31'd0, cp}, 32'd1);
        chk_counts("t4");
        prev = GT;

        // Clear on a commit edge wins over the increment; strobe still fires.
        a = 4'h0; b = 4'hF;
        step(4);
        clear_cnt = 1'b1;
        step(1);
        clear_cnt = 1'b0;
        exp_cnt = 0; exp_cnt2 = 0;
        chk_res("t5 clear", LT);
        chk("t5 pulse", {31'd0, cp}, 32'd1);
        chk("t5 pulse2", {31'd0, cp2}, 32'd1);
        chk_counts("t5");
        step(1);
        chk("t5 pulse off", {31'd0, cp}, 32'd0);
        prev = LT;

        // Reset mid-settle, then full latency to first commit.
        a = 4'hF; b = 4'h0;
        step(3);
        chk_res("t6 pre", LT);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t6 leds", {29'd0, ledr[2:0]}, 32'd0);
        chk("t6 hex", {24'd0, hex3}, 32'hFF);
        chk("t6 pulse", {31'd0, cp}, 32'd0);
        chk_counts("t6 rst");
        step(4);
        chk("t6 hex wait", {24'd0, hex3}, 32'hFF);
        step(1);
        chk_res("t6 commit", GT);
        chk("t6 commit pulse", {31'd0, cp}, 32'd0);
        chk_counts("t6 commit");

        // Hold in idle blocks the first commit until released.
        reset = 1'b1; hold = 1'b1;
        step(1);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("t7 idle hex", {24'd0, hex3}, 32'hFF);
        end
        hold = 1'b0;
        step(1);
        chk_res("t7 release", GT);
        chk("t7 pulse", {31'd0, cp}, 32'd0);
        chk_counts("t7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
